// File: rtl/output_buffer_pkg.sv
// Shared definitions for the output buffer path: default sizing and the FIFO status bundle.
package output_buffer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake, data and status bundle between the FIFO and its producer/consumer.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  logic                     flush;
  logic                     w_enable;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     r_enable;
  logic                     err_clear;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     r_valid;
  logic                     empty;
  logic                     full;
  logic                     almost_empty;
  logic                     almost_full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output flush, w_enable, data_in, r_enable, err_clear,
    input  data_out, r_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, w_enable, data_in, r_enable, err_clear,
    output data_out, r_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one registered read port.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when no read is accepted; a same-address write lands after the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: pointers, occupancy, threshold flags and sticky error flags.
module sync_fifo_param
  import output_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH         = DEFAULT_DEPTH,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  r_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] rd_data;
  fifo_status_t          status;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_ev;
  logic                  udf_ev;

  // Status decode from the registered occupancy.
  always_comb begin
    status              = '0;
    status.empty        = (count_q == '0);
    status.full         = (count_q == CNT_W'(DEPTH));
    status.almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
    status.almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
  end

  // Acceptance and error events, judged on pre-edge state; a read frees the slot for a write when full.
  always_comb begin
    rd_acc = bus.r_enable && !status.empty;
    wr_acc = bus.w_enable && (!status.full || rd_acc);
    ovf_ev = bus.w_enable && status.full && !rd_acc;
    udf_ev = bus.r_enable && status.empty;
  end

  // Pointers, occupancy and read-valid; flush overrides any transfer in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      r_valid_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      r_valid_q <= rd_acc;
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_ev || (overflow_q  && !bus.err_clear);
      underflow_q <= udf_ev || (underflow_q && !bus.err_clear);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc && !bus.flush),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (rd_acc && !bus.flush),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.data_out     = rd_data;
  assign bus.r_valid      = r_valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = status.empty;
  assign bus.full         = status.full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_WIDTH=8, DEPTH=16, thresholds 14/2).
module tb_sync_fifo_param;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH    (8),
    .DEPTH         (16),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count the outcome.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_enable  = 1'b0;
    bus.r_enable  = 1'b0;
    bus.flush     = 1'b0;
    bus.err_clear = 1'b0;
    bus.data_in   = '0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.w_enable = 1'b1;
    bus.data_in  = d;
    tick();
    bus.w_enable = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    check({tag, "_r_valid"},  32'(bus.r_valid), 32'h0);
    check({tag, "_empty"},    32'(bus.empty), 32'h1);
    check({tag, "_full"},     32'(bus.full), 32'h0);
    check({tag, "_aempty"},   32'(bus.almost_empty), 32'h1);
    check({tag, "_afull"},    32'(bus.almost_full), 32'h0);
    check({tag, "_count"},    32'(bus.count), 32'h0);
    check({tag, "_ovf"},      32'(bus.overflow), 32'h0);
    check({tag, "_udf"},      32'(bus.underflow), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    #3;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill 0..15: flags track count, then a write at full is an overflow.
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      check("fill_count",  32'(bus.count), 32'(i + 1));
      check("fill_afull",  32'(bus.almost_full), 32'((i + 1) >= 14));
      check("fill_aempty", 32'(bus.almost_empty), 32'((i + 1) <= 2));
      check("fill_full",   32'(bus.full), 32'(i == 15));
      check("fill_empty",  32'(bus.empty), 32'h0);
    end
    push(8'd99);
    check("ovf_flag",  32'(bus.overflow), 32'h1);
    check("ovf_count", 32'(bus.count), 32'd16);

    // Drain in order, then one read too many.
    bus.r_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain_data",  32'(bus.data_out), 32'(i));
      check("drain_valid", 32'(bus.r_valid), 32'h1);
      check("drain_count", 32'(bus.count), 32'(15 - i));
    end
    check("drain_empty", 32'(bus.empty), 32'h1);
    tick();
    bus.r_enable = 1'b0;
    check("udf_flag",  32'(bus.underflow), 32'h1);
    check("udf_valid", 32'(bus.r_valid), 32'h0);
    check("udf_hold",  32'(bus.data_out), 32'd15);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 32'h0);
    check("clr_udf", 32'(bus.underflow), 32'h0);

    // Steady state at count 8 across the pointer wrap.
    for (int i = 0; i < 8; i++) push(8'(100 + i));
    bus.w_enable = 1'b1;
    bus.r_enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.data_in = 8'(108 + k);
      tick();
      check("ss_data",  32'(bus.data_out), 32'(100 + k));
      check("ss_valid", 32'(bus.r_valid), 32'h1);
      check("ss_count", 32'(bus.count), 32'd8);
    end
    idle();
    check("ss_ovf", 32'(bus.overflow), 32'h0);
    check("ss_udf", 32'(bus.underflow), 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("ss_flush_count", 32'(bus.count), 32'h0);

    // Read+write at empty: read rejected, write accepted.
    bus.w_enable = 1'b1;
    bus.r_enable = 1'b1;
    bus.data_in  = 8'h33;
    tick();
    idle();
    check("rw_empty_udf",   32'(bus.underflow), 32'h1);
    check("rw_empty_count", 32'(bus.count), 32'h1);
    check("rw_empty_valid", 32'(bus.r_valid), 32'h0);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;

    // Read+write at full: both accepted, head word returned.
    for (int i = 0; i < 15; i++) push(8'(8'h40 + i));
    check("rw_full_pre", 32'(bus.full), 32'h1);
    bus.w_enable = 1'b1;
    bus.r_enable = 1'b1;
    bus.data_in  = 8'h77;
    tick();
    idle();
    check("rw_full_count", 32'(bus.count), 32'd16);
    check("rw_full_ovf",   32'(bus.overflow), 32'h0);
    check("rw_full_data",  32'(bus.data_out), 32'h33);
    check("rw_full_valid", 32'(bus.r_valid), 32'h1);

    // Flush beats a simultaneous write; data_out is untouched.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(i));
    check("pre_flush_count", 32'(bus.count), 32'd10);
    bus.flush    = 1'b1;
    bus.w_enable = 1'b1;
    bus.data_in  = 8'hEE;
    tick();
    idle();
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_empty", 32'(bus.empty), 32'h1);
    check("flush_valid", 32'(bus.r_valid), 32'h0);
    check("flush_data",  32'(bus.data_out), 32'h33);
    push(8'hA5);
    check("post_flush_count", 32'(bus.count), 32'h1);
    bus.r_enable = 1'b1;
    tick();
    bus.r_enable = 1'b0;
    check("post_flush_data",  32'(bus.data_out), 32'hA5);
    check("post_flush_valid", 32'(bus.r_valid), 32'h1);
    check("post_flush_empty", 32'(bus.empty), 32'h1);

    // Asynchronous reset mid-burst at count 5 with a live read word.
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    bus.w_enable = 1'b1;
    bus.r_enable = 1'b1;
    bus.data_in  = 8'h15;
    tick();
    check("burst_count", 32'(bus.count), 32'd5);
    check("burst_data",  32'(bus.data_out), 32'h10);
    idle();
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // A clear coinciding with a new underflow leaves the flag set.
    bus.r_enable = 1'b1;
    tick();
    check("err_set", 32'(bus.underflow), 32'h1);
    bus.err_clear = 1'b1;
    tick();
    check("err_set_wins", 32'(bus.underflow), 32'h1);
    bus.r_enable = 1'b0;
    tick();
    bus.err_clear = 1'b0;
    check("err_cleared", 32'(bus.underflow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for the output buffer path; successor to the fixed 8-bit dual-clock FIFO. Generic width and power-of-two depth, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. Sits between the packet formatter (write side) and the serialiser (read side) where both run on the same clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word
- DEPTH, 16, number of entries; power of two, at least 4
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents, pointers and count
- w_enable  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_enable  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- r_valid  out  1  data_out holds a word popped on the previous edge
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_THRESH
- almost_full  out  1  count >= AFULL_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full with no read accepted in the same cycle
- underflow  out  1  sticky: read attempted while empty
- err_clear  in  1  synchronous clear of overflow/underflow

## Operation
- Read accepted when r_enable && !empty, judged on pre-edge state.
- Write accepted when w_enable && (!full || read accepted in the same cycle).
- Pointers: $clog2(DEPTH) bits, natural wrap at DEPTH-1 -> 0. count +1 on write only, -1 on read only, unchanged on both or neither.
- Accepted read: data_out <= mem[rd_ptr], r_valid <= 1. Otherwise r_valid <= 0 and data_out holds its last value.
- Empty with simultaneous read and write: read rejected, underflow set, write accepted; count becomes 1.
- Full with simultaneous read and write: both accepted; count stays DEPTH; overflow not set.
- Flush has priority over reads and writes in the same cycle. It zeroes pointers and count and r_valid. data_out, the memory contents and the error flags are not affected.
- err_clear clears both error flags. If a new error event occurs in the same cycle, the flag is set (set wins).
- Flags are combinational from count, so they change in the same cycle as count.

## Timing
- Reset values: data_out 0, r_valid 0, empty 1, full 0, almost_empty 1, almost_full 0, count 0, overflow 0, underflow 0. Pointers are 0; memory is not reset.
- Reset asserted mid-operation: all of the above are immediate and asynchronous, and in-flight words are discarded.
- Write-to-read latency: a word written on edge N may be read with r_enable at edge N+1 and is on data_out after edge N+1. empty deasserts after edge N.
- Read latency: 1 cycle from accepted r_enable to data_out/r_valid.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package output_buffer_pkg:
  - default DATA_WIDTH/DEPTH constants
  - fifo_status_t packed struct {empty, full, almost_empty, almost_full}
- One sub-module, fifo_mem: DEPTH x DATA_WIDTH register array with one synchronous write port and one registered read port.
- Top holds pointer, count and flag logic.

## Test plan
- Reset, then write 0..15 on consecutive cycles (DEPTH=16) -> full after the 16th write, count=16, almost_full from count 14; a 17th write sets overflow and count stays 16.
- Read 16 from full -> data_out 0..15 in order, each with r_valid one cycle after its r_enable; empty after the last read; a 17th read sets underflow.
- Simultaneous read+write for 40 cycles starting at count=8 -> count stays 8, data order preserved across pointer wrap, no error flags.
- Simultaneous read+write at empty -> underflow=1, count=1; at full -> count=16, overflow=0, head word returned.
- Fill to 10, assert flush together with w_enable -> count=0, empty=1, r_valid=0, write ignored; next written word 0xA5 reads back as 0xA5.
- Assert rst mid-burst at count=5 -> all outputs take reset values immediately; err_clear with a simultaneous error event leaves the flag set.
